// File: rtl/pipeline_ctrl.sv
// Hazard controller for an N-stage in-order pipeline: per-stage stall/flush,
// a held fetch redirect, a registered exception flush pulse and saturating counters.
module pipeline_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 5,
    parameter int PREG_WIDTH = 6,
    parameter int LD_DEPTH   = 1,
    parameter int BR_STAGE   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    input  logic [STAGES-1:0]              stage_busy,
    input  logic [1:0]                     src_valid,
    input  logic [2*PREG_WIDTH-1:0]        src_addr,
    input  logic [LD_DEPTH-1:0]            ld_valid,
    input  logic [LD_DEPTH*PREG_WIDTH-1:0] ld_addr,
    input  logic                           br_take,
    input  logic [DATA_WIDTH-1:0]          br_target,
    input  logic                           exc_valid,
    input  logic [DATA_WIDTH-1:0]          exc_target,
    input  logic                           redirect_ready,
    input  logic                           cnt_clr,
    output logic [STAGES-1:0]              stall,
    output logic [STAGES-1:0]              flush,
    output logic                           redirect_valid,
    output logic [DATA_WIDTH-1:0]          redirect_target,
    output logic                           global_flush,
    output logic [CNT_WIDTH-1:0]           stall_cnt,
    output logic [CNT_WIDTH-1:0]           redirect_cnt
);

    logic [PREG_WIDTH-1:0] rs_addr;
    logic [PREG_WIDTH-1:0] rt_addr;
    logic                  load_use;
    logic [STAGES-1:0]     chain;
    logic [STAGES-1:0]     flush_core;
    logic                  br_fire;
    logic                  pend_valid;
    logic [DATA_WIDTH-1:0] pend_target;
    logic                  redirect_fire;
    logic                  stall_inc;

    assign rs_addr = src_addr[PREG_WIDTH-1:0];
    assign rt_addr = src_addr[2*PREG_WIDTH-1:PREG_WIDTH];

    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < LD_DEPTH; k++) begin
            if (ld_valid[k] &&
                ((src_valid[0] && rs_addr == ld_addr[k*PREG_WIDTH +: PREG_WIDTH]) ||
                 (src_valid[1] && rt_addr == ld_addr[k*PREG_WIDTH +: PREG_WIDTH])))
                load_use = 1'b1;
        end
    end

    // Stalls propagate from the oldest stage back toward fetch; a load-use
    // interlock holds only decode and fetch so the load itself keeps moving.
    always_comb begin
        chain = '0;
        chain[STAGES-1] = stage_busy[STAGES-1];
        for (int i = STAGES-2; i >= 0; i--) begin
            chain[i] = stage_busy[i] | chain[i+1] | ((i <= 1) ? load_use : 1'b0);
        end
    end

    assign br_fire = run & br_take & ~chain[BR_STAGE];

    always_comb begin
        flush_core = '0;
        flush_core[STAGES-1] = chain[STAGES-1];
        for (int i = 0; i < STAGES-1; i++) begin
            flush_core[i] = chain[i] & ~chain[i+1];
        end
        if (br_fire) begin
            for (int i = 0; i < BR_STAGE; i++) begin
                flush_core[i] = 1'b1;
            end
        end
        if (pend_valid)
            flush_core[0] = 1'b1;
    end

    always_comb begin
        stall = chain;
        flush = flush_core;
        if (exc_valid)
            flush = '1;
        if (!run) begin
            stall = '1;
            flush = '1;
        end
    end

    assign redirect_valid = run & (exc_valid | br_fire | pend_valid);
    assign redirect_fire  = redirect_valid & redirect_ready;

    always_comb begin
        redirect_target = pend_target;
        if (exc_valid)
            redirect_target = exc_target;
        else if (br_fire)
            redirect_target = br_target;
    end

    // The pending slot always captures the highest-priority target, so a newer
    // branch or exception replaces a redirect that fetch has not yet taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (redirect_valid) begin
            if (redirect_ready) begin
                pend_valid <= 1'b0;
            end else begin
                pend_valid  <= 1'b1;
                pend_target <= redirect_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            global_flush <= 1'b0;
        else
            global_flush <= exc_valid;
    end

    assign stall_inc = run & chain[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (cnt_clr)
                stall_cnt <= '0;
            else if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);

            if (cnt_clr)
                redirect_cnt <= '0;
            else if (redirect_fire && redirect_cnt != '1)
                redirect_cnt <= redirect_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Parametrised hazard controller for the N-stage in-order pipeline. It generates per-stage stall and flush vectors from stage-busy, load-use, branch and exception inputs. It owns a redirect register that holds a PC redirect until fetch accepts it, and it keeps saturating performance counters. It sits beside the datapath: it takes feedback from every stage and drives every pipeline register's stall/flush and the fetch redirect port.

## Interface
- DATA_WIDTH, 32, width of PC/target values
- STAGES, 5, pipeline depth (3..8); stage 0 = fetch, stage 1 = decode, stage STAGES-1 = write back
- PREG_WIDTH, 6, physical register address width
- LD_DEPTH, 1, number of stages after decode checked for load-use (1..STAGES-2); entry k = stage 2+k
- BR_STAGE, 2, stage that resolves branches (2..STAGES-2)
- CNT_WIDTH, 16, performance counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  core executing; 0 freezes and bubbles every stage
- stage_busy  in  STAGES  bit i: stage i cannot complete this cycle (fetch miss, memory wait, ...)
- src_valid  in  2  decode rs/rt read enables
- src_addr  in  2*PREG_WIDTH  decode rs (low field), rt (high field)
- ld_valid  in  LD_DEPTH  bit k: stage 2+k holds a load that writes a register
- ld_addr  in  LD_DEPTH*PREG_WIDTH  destination of the load in stage 2+k
- br_take  in  1  branch in BR_STAGE is taken
- br_target  in  DATA_WIDTH  taken-branch target
- exc_valid  in  1  exception/ERET request, PC vector already resolved
- exc_target  in  DATA_WIDTH  exception vector or EPC
- redirect_ready  in  1  fetch accepts the redirect this cycle
- cnt_clr  in  1  synchronous clear of both counters
- stall  out  STAGES  bit i: hold stage i's input register
- flush  out  STAGES  bit i: load a bubble into stage i's output register
- redirect_valid  out  1  redirect request to fetch
- redirect_target  out  DATA_WIDTH  redirect PC
- global_flush  out  1  one-cycle registered pulse after an exception
- stall_cnt  out  CNT_WIDTH  run cycles with stall[0]=1
- redirect_cnt  out  CNT_WIDTH  redirects accepted

## Operation
- When run=0, stall and flush are all-ones and no redirect fires. Counters and pend_valid hold their values.
- Interlock: il = OR over k of (ld_valid[k] and ((src_valid[0] and rs==ld_addr[k]) or (src_valid[1] and rt==ld_addr[k]))).
- Stall chain, combinational, from oldest to youngest:
  - stall[STAGES-1] = stage_busy[STAGES-1].
  - stall[i] = stage_busy[i] | stall[i+1].
  - stall[1] and stall[0] additionally OR in il.
- Bubble: flush[i] = 1 when stall[i] and not stall[i+1] (i < STAGES-1). flush[STAGES-1] = stall[STAGES-1].
- Branch fire: br_fire = br_take and not stall[BR_STAGE]. A taken branch held in a stalled stage has no effect until that stage advances.
  - On br_fire, flush[0..BR_STAGE-1] = 1.
- Exception has priority over everything: exc_valid forces flush to all-ones that cycle, and the stall outputs are ignored by the datapath.
- Redirect register: pend_valid / pend_target.
  - redirect_valid = exc_valid | br_fire | pend_valid.
  - Target priority: exc_target > br_target > pend_target.
  - Clock edge with redirect_valid and not redirect_ready: pend_valid <= 1, pend_target <= the selected target.
  - Clock edge with redirect_valid and redirect_ready: pend_valid <= 0.
  - While pend_valid = 1, flush[0] = 1, so wrong-path fetches are discarded.
- global_flush: registered, equals exc_valid of the previous cycle.
- Counters saturate at all-ones.
  - stall_cnt increments on run and stall[0].
  - redirect_cnt increments on redirect_valid and redirect_ready.
  - cnt_clr wins over increment.

## Timing
- Reset values: pend_valid 0, pend_target 0, global_flush 0, both counters 0.
- Outputs while rst_n = 0 (run is low in reset): stall and flush all-ones, redirect_valid 0.
- stall, flush and redirect_valid are combinational, with zero-cycle latency from their inputs.
- Redirect fetch handshake: a redirect is consumed on the first edge where redirect_valid and redirect_ready are both 1. The target stays stable while pending, unless a higher-priority source overwrites it.
- A new br_fire while pend_valid = 1 replaces pend_target. This is legal: the older pending redirect is already on a flushed path.
- An exception on the same cycle as br_fire selects exc_target.
- global_flush is high exactly one cycle, at the edge after exc_valid. Back-to-back exc_valid gives a continuous global_flush.
- An asynchronous reset mid-redirect drops the pending redirect immediately.

## Test plan
- Defaults, run=1, stage_busy=5'b01000 (memory wait) → stall=5'b01111, flush=5'b01000; drop busy → stall=0, flush=0.
- ld_valid=1, ld_addr=7, src_valid=2'b01, rs=7 → stall=5'b00011, flush=5'b00010; rs=8 → stall=0.
- br_take=1, br_target=0x400, redirect_ready=0 for 2 cycles, then 1 → redirect_valid for 3 cycles with target 0x400, flush[0]=1 throughout, flush[1:0]=2'b11 in the br_fire cycle, redirect_cnt=1 after acceptance.
- br_take with stage_busy[2]=1 → no redirect, no flush[1:0]; release busy → redirect fires that cycle.
- exc_valid with exc_target=0x80 in the same cycle as br_take with br_target=0x400 → redirect_target=0x80, flush=5'b11111; global_flush=1 for exactly the next cycle.
- CNT_WIDTH=2: hold stall[0] for 5 run cycles → stall_cnt=3 (saturated); cnt_clr → 0; assert rst_n=0 while pend_valid=1 → redirect_valid=0 immediately.
